// File: rtl/tree_reduce_pkg.sv
// Shared types and constants for the tree reduction sequencer.
package tree_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } tree_reduce_state_e;

  localparam int ACC_W = 32;
  localparam logic signed [ACC_W-1:0] ACC_MAX = 32'sh7FFFFFFF;
  localparam logic signed [ACC_W-1:0] ACC_MIN = 32'sh80000000;

endpackage

// File: rtl/binary_tree_adder.sv
// Combinational signed adder tree; each level is wide enough for the full sum, so no overflow.
module binary_tree_adder #(
  parameter int INPUTS_AMOUNT = 8,
  parameter int P             = 8,
  localparam int LEVELS       = $clog2(INPUTS_AMOUNT),
  localparam int OUT_W        = P + LEVELS
) (
  input  logic signed [P-1:0]     data [INPUTS_AMOUNT],
  output logic signed [OUT_W-1:0] sum
);

  genvar gl, gi;
  generate
    for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
      logic signed [OUT_W-1:0] v [INPUTS_AMOUNT >> gl];
      if (gl == 0) begin : g_leaf
        for (gi = 0; gi < INPUTS_AMOUNT; gi++) begin : g_in
          assign v[gi] = OUT_W'(data[gi]);
        end
      end else begin : g_node
        for (gi = 0; gi < (INPUTS_AMOUNT >> gl); gi++) begin : g_add
          assign v[gi] = g_lvl[gl-1].v[2*gi] + g_lvl[gl-1].v[2*gi+1];
        end
      end
    end
  endgenerate

  assign sum = g_lvl[LEVELS].v[0];

endmodule

// File: rtl/tree_reduce_sequencer.sv
// Multi-beat vector reduction around one shared adder tree.
// Optional macro TREE_REDUCE_SATURATE_EN: saturating accumulation with sticky out_sat_o.
module tree_reduce_sequencer
  import tree_reduce_pkg::*;
#(
  parameter int LANES = 8,
  parameter int P     = 8,
  parameter int CNT_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [CNT_W-1:0]        len_i,
  output logic                    busy_o,
  input  logic                    in_valid_i,
  output logic                    in_ready_o,
  input  logic signed [P-1:0]     in_data_i [LANES],
  output logic                    out_valid_o,
  input  logic                    out_ready_i,
  output logic signed [ACC_W-1:0] out_sum_o,
  output logic                    out_sat_o
);

  localparam int TREE_W = P + $clog2(LANES);

  generate
    if ((LANES < 1) || ((LANES & (LANES - 1)) != 0)) begin : g_bad_lanes
      $fatal(1, "LANES must be a power of 2");
    end
    if (TREE_W > ACC_W) begin : g_bad_width
      $fatal(1, "P + clog2(LANES) must not exceed 32");
    end
  endgenerate

  tree_reduce_state_e      state_reg, state_next;
  logic signed [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0]        cnt_reg, cnt_next;
  logic [CNT_W-1:0]        len_reg, len_next;

  logic signed [TREE_W-1:0] tree_sum;
  logic signed [ACC_W-1:0]  tree_ext;
  logic signed [ACC_W-1:0]  acc_sum;
  logic signed [ACC_W-1:0]  acc_step;
  logic                     beat_fire;

  binary_tree_adder #(
    .INPUTS_AMOUNT(LANES),
    .P            (P)
  ) u_tree (
    .data(in_data_i),
    .sum (tree_sum)
  );

  assign tree_ext  = ACC_W'(tree_sum);
  assign acc_sum   = acc_reg + tree_ext;
  assign beat_fire = in_valid_i && (state_reg == ACCUM);

`ifdef TREE_REDUCE_SATURATE_EN
  logic pos_ovf, neg_ovf, sat_reg;

  // Same-sign operands producing an opposite-sign result is the overflow signature.
  assign pos_ovf  = !acc_reg[ACC_W-1] && !tree_ext[ACC_W-1] && acc_sum[ACC_W-1];
  assign neg_ovf  = acc_reg[ACC_W-1] && tree_ext[ACC_W-1] && !acc_sum[ACC_W-1];
  assign acc_step = pos_ovf ? ACC_MAX : (neg_ovf ? ACC_MIN : acc_sum);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sat_reg <= 1'b0;
    end else if ((state_reg == IDLE) && start_i) begin
      sat_reg <= 1'b0;
    end else if (beat_fire && (pos_ovf || neg_ovf)) begin
      sat_reg <= 1'b1;
    end
  end

  assign out_sat_o = sat_reg;
`else
  assign acc_step  = acc_sum;
  assign out_sat_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cnt_reg   <= '0;
      len_reg   <= '0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cnt_reg   <= cnt_next;
      len_reg   <= len_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cnt_next   = cnt_reg;
    len_next   = len_reg;
    case (state_reg)
      IDLE: begin
        if (start_i) begin
          len_next   = len_i;
          acc_next   = '0;
          cnt_next   = '0;
          state_next = (len_i == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (beat_fire) begin
          acc_next = acc_step;
          cnt_next = cnt_reg + CNT_W'(1);
          // len_reg is never 0 here, so len_reg-1 cannot wrap.
          if (cnt_reg == (len_reg - CNT_W'(1))) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready_i) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_o      = (state_reg != IDLE);
  assign in_ready_o  = (state_reg == ACCUM);
  assign out_valid_o = (state_reg == DONE);
  assign out_sum_o   = acc_reg;

endmodule

// File: tb/tb_tree_reduce_sequencer.sv
// Scoreboard bench for tree_reduce_sequencer: expected sums queued at stimulus time, popped at result.
module tb_tree_reduce_sequencer;

  localparam int LANES = 8;
  localparam int P     = 8;
  localparam int CNT_W = 16;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [CNT_W-1:0]     len;
  logic                 busy;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [P-1:0]  in_data [LANES];
  logic                 out_valid;
  logic                 out_ready;
  logic signed [31:0]   out_sum;
  logic                 out_sat;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  tree_reduce_sequencer #(.LANES(LANES), .P(P), .CNT_W(CNT_W)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .start_i    (start),
    .len_i      (len),
    .busy_o     (busy),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sum_o  (out_sum),
    .out_sat_o  (out_sat)
  );

  function automatic int beat_val(input int mode, input int k);
    case (mode)
      0:       return k + 1;
      1:       return -128;
      2:       return 127;
      default: return 5;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int v);
    for (int l = 0; l < LANES; l++) in_data[l] = 8'(v);
  endtask

  // Starts a job, queues its expected sum and feeds beats until all are transferred or budget runs out.
  task automatic drive_job(input int jlen, input int mode, input bit toggle,
                           output int beats, output int ready_cycles, output int cyc);
    int  expv;
    bit  v;
    bit  rdy;
    expv = 0;
    for (int k = 0; k < jlen; k++) expv += LANES * beat_val(mode, k);
    exp_q.push_back(expv);
    start = 1'b1;
    len   = CNT_W'(jlen);
    tick();
    start = 1'b0;
    beats = 0;
    ready_cycles = 0;
    cyc = 0;
    while (beats < jlen && cyc < 2 * jlen + 20) begin
      if (in_ready) ready_cycles++;
      v = toggle ? (cyc % 2 == 0) : 1'b1;
      in_valid = v;
      if (v) set_beat(beat_val(mode, beats));
      else   set_beat(int'($urandom_range(0, 255)));
      rdy = in_ready;
      tick();
      cyc++;
      if (v && rdy) beats++;
    end
    in_valid = 1'b0;
  endtask

  // Waits (bounded) for a result and accepts it.
  task automatic accept_result();
    for (int i = 0; i < 20 && !out_valid; i++) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b0;
    set_beat(0);
    tick();
    tick();
    rst = 1'b0;
    n_checks += 5;
    if (busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    if (in_ready !== 1'b0)  begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (out_sum !== 32'sd0) begin n_fail++; $display("FAIL reset_out_sum: got %0d want 0", out_sum); end
    if (out_sat !== 1'b0)   begin n_fail++; $display("FAIL reset_out_sat: got %b want 0", out_sat); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    int beats, rc, cyc, expv;
    drive_job(3, 0, 1'b0, beats, rc, cyc);
    expv = exp_q.pop_front();
    n_checks += 5;
    if (beats !== 3)         begin n_fail++; $display("FAIL basic_beats: got %0d want 3", beats); end
    if (rc !== 3)            begin n_fail++; $display("FAIL basic_ready_cycles: got %0d want 3", rc); end
    if (out_valid !== 1'b1)  begin n_fail++; $display("FAIL basic_latency: out_valid got %b want 1", out_valid); end
    if (out_sum !== expv)    begin n_fail++; $display("FAIL basic_sum: got %0d want %0d", out_sum, expv); end
    if (out_sat !== 1'b0)    begin n_fail++; $display("FAIL basic_sat: got %b want 0", out_sat); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || out_sum !== expv) begin
        n_fail++;
        $display("FAIL basic_hold[%0d]: valid=%b busy=%b sum=%0d want 1 1 %0d", i, out_valid, busy, out_sum, expv);
      end
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== expv) begin
      n_fail++;
      $display("FAIL basic_after_accept: valid=%b busy=%b sum=%0d want 0 0 %0d", out_valid, busy, out_sum, expv);
    end
    $display("test_basic: len=3 sum=%0d expected=%0d", out_sum, expv);
  endtask

  task automatic test_len_zero();
    int beats, rc, cyc, expv;
    drive_job(0, 0, 1'b0, beats, rc, cyc);
    expv = exp_q.pop_front();
    n_checks += 2;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL zero_latency: valid=%b ready=%b want 1 0", out_valid, in_ready);
    end
    if (out_sum !== expv) begin n_fail++; $display("FAIL zero_sum: got %0d want %0d", out_sum, expv); end
    start = 1'b1;
    len   = CNT_W'(3);
    tick();
    start = 1'b0;
    n_checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== expv) begin
      n_fail++; $display("FAIL zero_start_in_done: valid=%b ready=%b sum=%0d want 1 0 %0d", out_valid, in_ready, out_sum, expv);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL zero_no_queue: busy got %b want 0", busy); end
    $display("test_len_zero: sum=%0d expected=%0d", out_sum, expv);
  endtask

  task automatic test_toggle_valid();
    int beats, rc, cyc, expv;
    drive_job(4, 1, 1'b1, beats, rc, cyc);
    expv = exp_q.pop_front();
    n_checks += 3;
    if (cyc + 1 !== 8)      begin n_fail++; $display("FAIL toggle_cycles: got %0d want 8", cyc + 1); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL toggle_valid: got %b want 1", out_valid); end
    if (out_sum !== expv)   begin n_fail++; $display("FAIL toggle_sum: got %0d want %0d", out_sum, expv); end
    $display("test_toggle_valid: sum=%0d expected=%0d", out_sum, expv);
    accept_result();
  endtask

  task automatic test_mid_reset();
    int beats, rc, cyc, expv;
    start = 1'b1;
    len   = CNT_W'(5);
    tick();
    start = 1'b0;
    in_valid = 1'b1;
    set_beat(9);
    tick();
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0 || out_sum !== 32'sd0 || out_sat !== 1'b0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%b ready=%b valid=%b sum=%0d sat=%b want all 0",
               busy, in_ready, out_valid, out_sum, out_sat);
    end
    drive_job(1, 3, 1'b0, beats, rc, cyc);
    expv = exp_q.pop_front();
    n_checks++;
    if (out_valid !== 1'b1 || out_sum !== expv) begin
      n_fail++; $display("FAIL midreset_new_job: valid=%b sum=%0d want 1 %0d", out_valid, out_sum, expv);
    end
    $display("test_mid_reset: new job sum=%0d expected=%0d", out_sum, expv);
    accept_result();
  endtask

  task automatic test_max_len();
    int beats, rc, cyc, expv;
    drive_job(65535, 2, 1'b0, beats, rc, cyc);
    expv = exp_q.pop_front();
    n_checks += 3;
    if (beats !== 65535)    begin n_fail++; $display("FAIL maxlen_beats: got %0d want 65535", beats); end
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL maxlen_valid: got %b want 1", out_valid); end
    if (out_sum !== expv || out_sat !== 1'b0) begin
      n_fail++; $display("FAIL maxlen_sum: got %0d sat=%b want %0d sat=0", out_sum, out_sat, expv);
    end
    $display("test_max_len: sum=%0d expected=%0d", out_sum, expv);
    accept_result();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_len_zero();
    test_toggle_valid();
    test_mid_reset();
    test_max_len();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tree_reduce_sequencer.md
Name: tree_reduce_sequencer

Overview:
- Sequences one shared combinational `binary_tree_adder` instance over a multi-beat vector and reduces the vector to a single 32-bit signed sum.
- Per job:
  - Accepts a start command with a beat count.
  - Consumes LANES-wide beats of P-bit signed elements over a valid/ready stream.
  - Sums each beat with the tree and accumulates the beat sums.
  - Presents the final sum on a valid/ready result port.
- Sits between an operand streamer and the result writeback in the accelerator datapath.

Parameters:
- LANES, 8, elements per beat; must be a power of 2 (elaboration `$fatal` otherwise).
- P, 8, element width in bits; P + $clog2(LANES) <= 32 is required (elaboration `$fatal` otherwise).
- CNT_W, 16, width of the beat counter and of `len_i`.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- rst_i  input  1  synchronous, active-high reset.
- start_i  input  1  job start pulse; sampled only in IDLE.
- len_i  input  CNT_W  beats in the job; sampled with `start_i`.
- busy_o  output  1  high whenever state != IDLE.
- in_valid_i  input  1  input beat valid.
- in_ready_o  output  1  input beat ready.
- in_data_i  input  signed [P-1:0] x LANES (unpacked array)  beat elements.
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  result accepted by consumer.
- out_sum_o  output  32  signed accumulated result.
- out_sat_o  output  1  saturation occurred in the job; constant 0 unless the optional feature is enabled.

Behaviour:
- Reset (`rst_i` = 1 at a rising edge; synchronous, active-high):
  - state=IDLE; acc=0; cnt=0; len_q=0; sat_q=0.
  - All outputs 0: `busy_o`, `in_ready_o`, `out_valid_o`, `out_sum_o`, `out_sat_o`.
  - A mid-job reset abandons the job: no result is produced and no partial state is retained.
- FSM states: IDLE, ACCUM, DONE.
- IDLE:
  - On `start_i`=1: len_q<=`len_i`, acc<=0, cnt<=0, sat_q<=0.
  - If `len_i`==0, go to DONE (result 0); otherwise go to ACCUM.
- ACCUM:
  - `in_ready_o`=1, driven combinationally from state; it is 0 in all other states.
  - A beat transfers when `in_valid_i` && `in_ready_o`.
  - On transfer: acc <= acc + tree_sum, where tree_sum is the 32-bit sign-extended tree output; cnt <= cnt+1.
  - If the transfer occurs while cnt == len_q-1, go to DONE in the same edge.
  - With no transfer, state, acc and cnt hold.
- DONE:
  - `out_valid_o`=1; `out_sum_o`=acc; `out_sat_o`=sat_q. All are registered and stay stable until handshake.
  - On `out_valid_o` && `out_ready_i`: go to IDLE. `out_valid_o` drops the next cycle; `out_sum_o` keeps its last value.
- `start_i` is ignored in ACCUM and DONE; no queuing.
- Latency:
  - First beat is accepted no earlier than 1 cycle after `start_i`.
  - `out_valid_o` rises 1 cycle after the final beat transfer.
  - `len_i`=0 gives `out_valid_o` 1 cycle after `start_i`.
  - Minimum cycles from `start_i` to `out_valid_o` = `len_i` + 1 (for `len_i` >= 1).
- Arithmetic:
  - The tree output is already wide enough that it never overflows.
  - The accumulator is 32-bit two's complement and wraps silently on overflow (default build).
- `len_i` = 2^CNT_W-1 must work: the cnt compare uses len_q-1, and len_q=0 never reaches ACCUM.

Optional Feature:
- Macro: `TREE_REDUCE_SATURATE_EN`.
- Defined:
  - The accumulate step saturates to 32'h7FFFFFFF on positive overflow and to 32'h80000000 on negative overflow.
  - sat_q is set sticky for the rest of the job and reported on `out_sat_o` in DONE.
  - Overflow is detected from operand signs versus result sign.
- Not defined: wrap-around as above; `out_sat_o` is tied 0 and no saturation logic is present.

Decomposition:
- Package `tree_reduce_pkg`:
  - State enum typedef `tree_reduce_state_e` {IDLE, ACCUM, DONE}.
  - `localparam` ACC_W=32.
  - ACC_MAX=32'sh7FFFFFFF and ACC_MIN=32'sh80000000.
- Sub-module: the existing `binary_tree_adder` (INPUTS_AMOUNT=LANES, P=P), instantiated once and fed directly from `in_data_i`. No other sub-module.

Test Plan:
- LANES=8, P=8:
  - `start_i`, `len_i`=3; beats all 1, all 2, all 3; `in_valid_i` continuous.
  - Required: `in_ready_o` high for 3 cycles; `out_sum_o`=48, `out_valid_o` 1 cycle after the 3rd beat.
  - `out_ready_i` held low for 5 cycles: sum stable, `busy_o`=1 throughout.
- `len_i`=0 → `out_valid_o` the cycle after start, `out_sum_o`=0; no beats consumed; `start_i` pulsed during DONE is ignored.
- `len_i`=4, beats of all -128; `in_valid_i` toggled 1/0 each cycle → `out_sum_o`=-4096 (32'hFFFFF000), completes after 8 beat cycles.
- `len_i`=5; `rst_i` asserted after the 2nd beat → next cycle all outputs 0, state IDLE. A new start with `len_i`=1 and a beat of all 5 then gives 40.
- Default build, `len_i`=2^16-1, beats all 127 (beat sum 1016) → `out_sum_o`=66583560; verifies cnt boundary. Result is wrap-free.
- `TREE_REDUCE_SATURATE_EN` overflow check:
  - Preload the job with enough +1016 beats to exceed 2^31 (test harness uses CNT_W=24, `len_i`=2200000).
  - With the macro: `out_sum_o`=32'h7FFFFFFF, `out_sat_o`=1.
  - Without the macro: wrapped value, `out_sat_o`=0.
